// File: rtl/board_writer_pkg.sv
// board_writer shared definitions: cell/error encodings, FSM states,
// win-line table and a cell lookup helper.
package board_writer_pkg;

  localparam int N_CELLS = 9;
  localparam int CELL_W  = 2;
  localparam int BOARD_W = N_CELLS * CELL_W;
  localparam int N_LINES = 8;

  localparam logic       FIRST_PLAYER = 1'b0;
  localparam logic [3:0] MAX_MOVES    = 4'd9;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_X     = 2'b01;
  localparam logic [1:0] CELL_O     = 2'b10;

  localparam logic [2:0] ERR_NONE  = 3'b000;
  localparam logic [2:0] ERR_RANGE = 3'b001;
  localparam logic [2:0] ERR_OCC   = 3'b010;
  localparam logic [2:0] ERR_TURN  = 3'b011;
  localparam logic [2:0] ERR_FULL  = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_COMMIT
  } state_e;

  // Lines 7..0: diagonals, columns, rows (cell indices per line)
  localparam logic [N_LINES-1:0][2:0][3:0] WIN_LINES = {
    4'd2, 4'd4, 4'd6,
    4'd0, 4'd4, 4'd8,
    4'd2, 4'd5, 4'd8,
    4'd1, 4'd4, 4'd7,
    4'd0, 4'd3, 4'd6,
    4'd6, 4'd7, 4'd8,
    4'd3, 4'd4, 4'd5,
    4'd0, 4'd1, 4'd2
  };

  // Out-of-range indices read as empty
  function automatic logic [CELL_W-1:0] cell_get(
    input logic [BOARD_W-1:0] b,
    input logic [3:0]         idx
  );
    cell_get = CELL_EMPTY;
    for (int i = 0; i < N_CELLS; i++) begin
      if (idx == 4'(i)) cell_get = b[i*CELL_W +: CELL_W];
    end
  endfunction

endpackage

// File: rtl/board_line_check.sv
// Combinational three-in-a-row detector over the flattened board.
// Built only with BOARD_WRITER_WIN_DETECT_EN defined.
`ifdef BOARD_WRITER_WIN_DETECT_EN
module board_line_check
  import board_writer_pkg::*;
(
  input  logic [BOARD_W-1:0] board_i,
  output logic               x_win_o,
  output logic               o_win_o
);

  // Scan all eight lines for a uniform X or O line
  always_comb begin
    x_win_o = 1'b0;
    o_win_o = 1'b0;
    for (int l = 0; l < N_LINES; l++) begin
      if (cell_get(board_i, WIN_LINES[l][0]) == CELL_X &&
          cell_get(board_i, WIN_LINES[l][1]) == CELL_X &&
          cell_get(board_i, WIN_LINES[l][2]) == CELL_X)
        x_win_o = 1'b1;
      if (cell_get(board_i, WIN_LINES[l][0]) == CELL_O &&
          cell_get(board_i, WIN_LINES[l][1]) == CELL_O &&
          cell_get(board_i, WIN_LINES[l][2]) == CELL_O)
        o_win_o = 1'b1;
    end
  end

endmodule
`endif

// File: rtl/board_writer.sv
// Validated move writer owning the authoritative board state.
// Optional win/draw detection under BOARD_WRITER_WIN_DETECT_EN.
module board_writer
  import board_writer_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               mv_valid,
  output logic               mv_ready,
  input  logic [3:0]         mv_pos,
  input  logic               mv_player,
  output logic               wr_done,
  output logic               wr_err,
  output logic [2:0]         err_code,
  output logic [BOARD_W-1:0] board,
  output logic [3:0]         move_cnt,
`ifdef BOARD_WRITER_WIN_DETECT_EN
  output logic [1:0]         winner,
  output logic               game_over,
`endif
  output logic               turn
);

  state_e state_q, state_d;

  logic [3:0]         pos_q, pos_d;
  logic               player_q, player_d;
  logic [2:0]         code_q, code_d;
  logic [BOARD_W-1:0] board_q, board_d;
  logic [BOARD_W-1:0] board_wr;
  logic [3:0]         cnt_q, cnt_d;
  logic               turn_q, turn_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [2:0]         ecode_q, ecode_d;
  logic [2:0]         chk_code;
  logic               full;

`ifdef BOARD_WRITER_WIN_DETECT_EN
  logic [1:0] winner_q, winner_d;
  logic       over_q, over_d;
  logic       x_win, o_win;

  board_line_check u_line_check (
    .board_i (board_wr),
    .x_win_o (x_win),
    .o_win_o (o_win)
  );

  assign full = (cnt_q == MAX_MOVES) || over_q;
`else
  assign full = (cnt_q == MAX_MOVES);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n || clear) state_q <= S_IDLE;
    else                 state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (mv_valid) state_d = S_CHECK;
      S_CHECK:  state_d = S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    mv_ready = (state_q == S_IDLE);
  end

  // Move validation, first failing check wins
  always_comb begin
    if (full)
      chk_code = ERR_FULL;
    else if (pos_q > 4'(N_CELLS - 1))
      chk_code = ERR_RANGE;
    else if (cell_get(board_q, pos_q) != CELL_EMPTY)
      chk_code = ERR_OCC;
    else if (player_q != turn_q)
      chk_code = ERR_TURN;
    else
      chk_code = ERR_NONE;
  end

  // Board image with only the addressed cell replaced
  always_comb begin
    board_wr = board_q;
    for (int i = 0; i < N_CELLS; i++) begin
      if (pos_q == 4'(i))
        board_wr[i*CELL_W +: CELL_W] = {player_q, ~player_q};
    end
  end

  // Datapath next-state
  always_comb begin
    pos_d    = pos_q;
    player_d = player_q;
    code_d   = code_q;
    board_d  = board_q;
    cnt_d    = cnt_q;
    turn_d   = turn_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    ecode_d  = ERR_NONE;
`ifdef BOARD_WRITER_WIN_DETECT_EN
    winner_d = winner_q;
    over_d   = over_q;
`endif
    if (state_q == S_IDLE && mv_valid) begin
      pos_d    = mv_pos;
      player_d = mv_player;
    end
    if (state_q == S_CHECK) code_d = chk_code;
    if (state_q == S_COMMIT) begin
      if (code_q == ERR_NONE) begin
        board_d = board_wr;
        cnt_d   = (cnt_q == MAX_MOVES) ? cnt_q : cnt_q + 4'd1;
        turn_d  = ~turn_q;
        done_d  = 1'b1;
`ifdef BOARD_WRITER_WIN_DETECT_EN
        if (x_win)                   winner_d = 2'b01;
        else if (o_win)              winner_d = 2'b10;
        else if (cnt_d == MAX_MOVES) winner_d = 2'b11;
        else                         winner_d = 2'b00;
        over_d = (winner_d != 2'b00);
`endif
      end else begin
        err_d   = 1'b1;
        ecode_d = code_q;
      end
    end
  end

  // Datapath registers; reset and clear both start a new game
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      pos_q    <= '0;
      player_q <= 1'b0;
      code_q   <= ERR_NONE;
      board_q  <= '0;
      cnt_q    <= '0;
      turn_q   <= FIRST_PLAYER;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ecode_q  <= ERR_NONE;
`ifdef BOARD_WRITER_WIN_DETECT_EN
      winner_q <= 2'b00;
      over_q   <= 1'b0;
`endif
    end else begin
      pos_q    <= pos_d;
      player_q <= player_d;
      code_q   <= code_d;
      board_q  <= board_d;
      cnt_q    <= cnt_d;
      turn_q   <= turn_d;
      done_q   <= done_d;
      err_q    <= err_d;
      ecode_q  <= ecode_d;
`ifdef BOARD_WRITER_WIN_DETECT_EN
      winner_q <= winner_d;
      over_q   <= over_d;
`endif
    end
  end

  assign wr_done  = done_q;
  assign wr_err   = err_q;
  assign err_code = ecode_q;
  assign board    = board_q;
  assign move_cnt = cnt_q;
  assign turn     = turn_q;
`ifdef BOARD_WRITER_WIN_DETECT_EN
  assign winner    = winner_q;
  assign game_over = over_q;
`endif

endmodule

// File: doc/board_writer.md
Name: board_writer

Overview:
- Write-side counterpart of the 9-way cell select mux: takes a move request (cell index, player) and commits it into one of nine board cell registers.
- Validates each move (range, occupancy, turn order, board full) and then either writes or reports an error.
- Sits between the game controller / input decoder and the board-read mux. It owns the authoritative board state.

Parameters:
- N_CELLS, 9, number of board cells; legal indices are 0..N_CELLS-1.
- CELL_W, 2, bits per cell: 00 empty, 01 X, 10 O, 11 reserved (never written).
- FIRST_PLAYER, 0, player expected after reset or clear (0 = X, 1 = O).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- clear  in  1  synchronous board clear (new game); active high.
- mv_valid  in  1  move request valid.
- mv_ready  out  1  block can accept a move.
- mv_pos  in  4  target cell index.
- mv_player  in  1  mover: 0 = X, 1 = O.
- wr_done  out  1  one-cycle pulse: move committed.
- wr_err  out  1  one-cycle pulse: move rejected.
- err_code  out  3  reason for rejection; valid while wr_err = 1, else 000.
- board  out  N_CELLS*CELL_W  flattened cells; cell i occupies bits [2i+1:2i].
- move_cnt  out  4  number of committed moves, 0..9.
- turn  out  1  player expected next.

Behaviour:
- Reset (rst_n = 0 at a clock edge):
  - board = 0, move_cnt = 0, turn = FIRST_PLAYER.
  - wr_done = 0, wr_err = 0, err_code = 000, state = IDLE, mv_ready = 1.
- Priority: rst_n over clear over everything else. clear has the same effect as reset, with no done or error pulse. clear in CHECK or COMMIT aborts the move.
- FSM states: IDLE, CHECK, COMMIT.
  - IDLE: mv_ready = 1. If mv_valid = 1 at an edge, latch mv_pos and mv_player and go to CHECK.
  - CHECK: mv_ready = 0. Evaluate checks in priority order, register the first failing code (or 000), go to COMMIT:
    - 100: board full (move_cnt == 9).
    - 001: mv_pos > N_CELLS-1.
    - 010: target cell not 00.
    - 011: mv_player != turn.
  - COMMIT: mv_ready = 0.
    - Code 000: write cell = {player, ~player}, i.e. X -> 01, O -> 10. Increment move_cnt, toggle turn, assert wr_done next cycle.
    - Otherwise: no state change, assert wr_err next cycle with err_code.
    - Go to IDLE.
- Latency:
  - Handshake in cycle T; result visible in cycle T+3.
  - At T+3: board, move_cnt and turn are updated; wr_done or wr_err is high for exactly one cycle; mv_ready = 1.
  - A new handshake is accepted in T+3, so throughput is one move per 3 cycles.
- mv_valid while mv_ready = 0 is ignored. The requester holds the request until it sees mv_ready.
- Exactly one of wr_done or wr_err pulses per accepted move; never both.
- Only the addressed cell changes. Cells 9..15 are never addressed.
- move_cnt saturates at 9 and never wraps.

Optional Feature:
- Macro: BOARD_WRITER_WIN_DETECT_EN.
- Defined:
  - Adds outputs winner[1:0] (00 none, 01 X, 10 O, 11 draw) and game_over.
  - Both are registered and updated in the same cycle as the committing write.
  - Win is detected over the 8 lines (3 rows, 3 columns, 2 diagonals). Draw is move_cnt == 9 with no line complete.
  - Once game_over = 1, every move is rejected with code 100. winner and game_over are cleared by reset or clear.
- Undefined: the ports and logic are absent. Code 100 fires only on move_cnt == 9.

Decomposition:
- Shared package:
  - Cell encodings: CELL_EMPTY, CELL_X, CELL_O.
  - Error codes: ERR_NONE, ERR_RANGE, ERR_OCC, ERR_TURN, ERR_FULL.
  - FSM state encoding.
  - N_CELLS.
  - Win-line index constant table.
- One sub-module, board_line_check: combinational 3-in-a-row detector over the board, instantiated only under BOARD_WRITER_WIN_DETECT_EN.

Test Plan:
- Reset, then mv_pos = 4, mv_player = 0 -> at T+3: wr_done = 1 for one cycle, board[9:8] = 01, move_cnt = 1, turn = 1, all other cells 00.
- Move pos 4 by X, then pos 4 by O -> second move: wr_err = 1, err_code = 010, board and move_cnt unchanged.
- After reset, O moves to pos 0 -> err_code = 011; then mv_pos = 9 by X -> err_code = 001.
- Nine legal alternating moves, then a tenth move -> move_cnt = 9, tenth move returns err_code = 100, mv_ready = 1 afterwards.
- Assert clear during CHECK -> no done or error pulse; board = 0, move_cnt = 0, turn = FIRST_PLAYER; rst_n low mid-COMMIT gives the same result.
- With BOARD_WRITER_WIN_DETECT_EN: X at 0, 4, 8 and O at 1, 2 -> winner = 01 and game_over = 1 in the cycle X's move at 8 commits; the next move gets err_code = 100.
